clk_div_ctrl: RTL and testbench

- Programmable clock-divider controller for the NMR pulse and acquisition timing chain.
- Generates a divided clock `clk_out` from `clk_in` and sequences it under a start/stop/burst protocol.
- Accepts new divide ratios through a valid/ready handshake; a ratio change while running is deferred to the next period boundary so `clk_out` never glitches.
- Downstream logic uses `clk_en_pulse` as a single-cycle strobe and `busy`/`done` for sequencing.

---
 rtl/clk_div_ctrl.sv | 148 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable divided-clock generator
// with start/stop/burst sequencing and deferred ratio change.
module clk_div_ctrl #(
    parameter int CNT_W        = 16,
    parameter int BURST_W      = 16,
    parameter int DEFAULT_HALF = 9
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   cfg_half,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               start,
    input  logic               stop,
    output logic               clk_out,
    output logic               clk_en_pulse,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] edge_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   half_reg;
    logic [BURST_W-1:0] burst_reg;
    logic [CNT_W-1:0]   sh_half;
    logic [BURST_W-1:0] sh_burst;
    logic               pending;

    logic               xfer;
    logic               tick;
    logic               fall;
    logic               burst_hit;
    logic [BURST_W-1:0] edge_nxt;

    assign cfg_ready = !pending;
    assign xfer      = cfg_valid && cfg_ready;
    assign busy      = (state == S_RUN) || (state == S_STOP);
    assign done      = (state == S_DONE);
    assign tick      = busy && (cnt == half_reg);
    assign fall      = tick && clk_out;
    assign edge_nxt  = (&edge_cnt) ? edge_cnt
                                   : edge_cnt + BURST_W'(1);
    assign burst_hit = fall && (burst_reg != '0)
                       && (edge_nxt == burst_reg);

    // State register; reset aborts any run without a done pulse.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state: stop wins over start; a stop in the low phase
    // ends at once, in the high phase it waits for the falling edge.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (start && !stop) next_state = S_RUN;
            end
            S_RUN: begin
                if ((stop && !clk_out) || burst_hit || (fall && stop))
                    next_state = S_DONE;
                else if (stop)
                    next_state = S_STOP;
            end
            S_STOP: begin
                if (fall) next_state = S_DONE;
            end
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Counter, output clock and config registers; shadow config is
    // only committed on a falling edge (or at run end) to avoid runts.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            clk_out      <= 1'b0;
            clk_en_pulse <= 1'b0;
            edge_cnt     <= '0;
            half_reg     <= CNT_W'(DEFAULT_HALF);
            burst_reg    <= '0;
            sh_half      <= '0;
            sh_burst     <= '0;
            pending      <= 1'b0;
        end else begin
            clk_en_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    clk_out <= 1'b0;
                    cnt     <= '0;
                    if (xfer) begin
                        half_reg  <= cfg_half;
                        burst_reg <= cfg_burst;
                    end
                    if (next_state == S_RUN) edge_cnt <= '0;
                end
                S_RUN, S_STOP: begin
                    if (next_state == S_DONE && !fall) begin
                        clk_out <= 1'b0;
                        cnt     <= '0;
                    end else if (tick) begin
                        cnt          <= '0;
                        clk_out      <= !clk_out;
                        clk_en_pulse <= !clk_out;
                        if (clk_out) edge_cnt <= edge_nxt;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (fall && pending) begin
                        half_reg  <= sh_half;
                        burst_reg <= sh_burst;
                        pending   <= 1'b0;
                    end else if (xfer) begin
                        sh_half  <= cfg_half;
                        sh_burst <= cfg_burst;
                        pending  <= 1'b1;
                    end
                end
                S_DONE: begin
                    clk_out <= 1'b0;
                    cnt     <= '0;
                    if (pending) begin
                        half_reg  <= sh_half;
                        burst_reg <= sh_burst;
                        pending   <= 1'b0;
                    end else if (xfer) begin
                        half_reg  <= cfg_half;
                        burst_reg <= cfg_burst;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed vector table plus
// hand sequences for stop, reconfig and reset corners.
module tb_clk_div_ctrl;

    logic        clk_in;
    logic        rst_n;
    logic [15:0] cfg_half;
    logic [15:0] cfg_burst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        start;
    logic        stop;
    logic        clk_out;
    logic        clk_en_pulse;
    logic        busy;
    logic        done;
    logic [15:0] edge_cnt;

    clk_div_ctrl #(
        .CNT_W(16),
        .BURST_W(16),
        .DEFAULT_HALF(9)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .cfg_half    (cfg_half),
        .cfg_burst   (cfg_burst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .start       (start),
        .stop        (stop),
        .clk_out     (clk_out),
        .clk_en_pulse(clk_en_pulse),
        .busy        (busy),
        .done        (done),
        .edge_cnt    (edge_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        bit co;
        bit en;
        bit bsy;
        bit dn;
        int ec;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic add(input int c, input bit co, input bit en,
                       input bit b, input bit d, input int ec);
        vec_t v;
        v.cyc = c; v.co = co; v.en = en;
        v.bsy = b; v.dn = d; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic adv(input int c);
        while (cyc < c) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_seg(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            adv(tbl[i].cyc);
            chk($sformatf("v%0d clk_out", i), 32'(clk_out), 32'(tbl[i].co));
            chk($sformatf("v%0d en", i), 32'(clk_en_pulse), 32'(tbl[i].en));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("v%0d edge_cnt", i), 32'(edge_cnt), tbl[i].ec);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic load(input int h, input int b);
        cfg_half  = 16'(h);
        cfg_burst = 16'(b);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // default ratio, free-running (idx 0..11)
        add(0,  0, 0, 1, 0, 0);
        add(9,  0, 0, 1, 0, 0);
        add(10, 1, 1, 1, 0, 0);
        add(11, 1, 0, 1, 0, 0);
        add(19, 1, 0, 1, 0, 0);
        add(20, 0, 0, 1, 0, 1);
        add(29, 0, 0, 1, 0, 1);
        add(30, 1, 1, 1, 0, 1);
        add(31, 1, 0, 1, 0, 1);
        add(40, 0, 0, 1, 0, 2);
        add(50, 1, 1, 1, 0, 2);
        add(60, 0, 0, 1, 0, 3);
        // half=1 burst=4 (idx 12..19)
        add(0,  0, 0, 1, 0, 0);
        add(2,  1, 1, 1, 0, 0);
        add(3,  1, 0, 1, 0, 0);
        add(4,  0, 0, 1, 0, 1);
        add(15, 1, 0, 1, 0, 3);
        add(16, 0, 0, 0, 1, 4);
        add(17, 0, 0, 0, 0, 4);
        add(20, 0, 0, 0, 0, 4);
        // half=0 burst=2 (idx 20..24)
        add(1,  1, 1, 1, 0, 0);
        add(2,  0, 0, 1, 0, 1);
        add(3,  1, 1, 1, 0, 1);
        add(4,  0, 0, 0, 1, 2);
        add(5,  0, 0, 0, 0, 2);

        rst_n = 1'b0; cfg_half = '0; cfg_burst = '0;
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst clk_out", 32'(clk_out), 0);
        chk("rst en", 32'(clk_en_pulse), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst ready", 32'(cfg_ready), 1);
        chk("rst edge_cnt", 32'(edge_cnt), 0);

        do_start();
        run_seg(0, 11);
        stop = 1'b1;
        tick(); cyc++;
        stop = 1'b0;
        chk("lowstop done", 32'(done), 1);
        chk("lowstop busy", 32'(busy), 0);
        chk("lowstop edge_cnt", 32'(edge_cnt), 3);
        chk("lowstop clk_out", 32'(clk_out), 0);
        tick(); cyc++;
        chk("lowstop done end", 32'(done), 0);

        load(1, 4);
        do_start();
        run_seg(12, 19);

        load(9, 0);
        do_start();
        adv(13);
        stop = 1'b1;
        tick(); cyc++;
        stop = 1'b0;
        chk("histop busy", 32'(busy), 1);
        chk("histop clk_out", 32'(clk_out), 1);
        adv(19);
        chk("histop hold", 32'(clk_out), 1);
        adv(20);
        chk("histop fall", 32'(clk_out), 0);
        chk("histop done", 32'(done), 1);
        chk("histop edge_cnt", 32'(edge_cnt), 1);
        adv(21);
        chk("histop done end", 32'(done), 0);

        do_start();
        adv(13);
        cfg_half = 16'd4; cfg_burst = 16'd0; cfg_valid = 1'b1;
        tick(); cyc++;
        cfg_valid = 1'b0;
        chk("recfg ready lo", 32'(cfg_ready), 0);
        adv(19);
        chk("recfg hi hold", 32'(clk_out), 1);
        chk("recfg ready still", 32'(cfg_ready), 0);
        adv(20);
        chk("recfg fall", 32'(clk_out), 0);
        chk("recfg ready back", 32'(cfg_ready), 1);
        adv(21);
        start = 1'b1;
        tick(); cyc++;
        start = 1'b0;
        adv(24);
        chk("recfg low hold", 32'(clk_out), 0);
        chk("busy start ign", 32'(edge_cnt), 1);
        adv(25);
        chk("recfg rise", 32'(clk_out), 1);
        chk("recfg en", 32'(clk_en_pulse), 1);
        adv(29);
        chk("recfg hi5", 32'(clk_out), 1);
        adv(30);
        chk("recfg fall2", 32'(clk_out), 0);
        chk("recfg edge_cnt", 32'(edge_cnt), 2);
        adv(35);
        chk("pre-rst clk_out", 32'(clk_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst clk_out", 32'(clk_out), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst done", 32'(done), 0);
        tick();
        chk("rst hold done", 32'(done), 0);
        rst_n = 1'b1;
        tick();
        chk("post rst edge_cnt", 32'(edge_cnt), 0);
        chk("post rst ready", 32'(cfg_ready), 1);

        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start+stop busy", 32'(busy), 0);
        tick();
        chk("start+stop clk_out", 32'(clk_out), 0);
        chk("start+stop busy2", 32'(busy), 0);

        load(0, 2);
        do_start();
        run_seg(20, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
